// File: rtl/disp_pkg.sv
// Shared constants for the MM:SS seven-segment scan display.
// Segment patterns are {g,f,e,d,c,b,a}, active low (common anode).
package disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] SLOT_S1  = 2'd0;
    localparam logic [1:0] SLOT_S10 = 2'd1;
    localparam logic [1:0] SLOT_M1  = 2'd2;
    localparam logic [1:0] SLOT_M10 = 2'd3;

    typedef struct packed {
        logic [2:0] min10;
        logic [3:0] min1;
        logic [2:0] sec10;
        logic [3:0] sec1;
    } disp_time_t;

endpackage

// File: rtl/clock_disp_scan_if.sv
// Time-in / display-out bundle of the MM:SS scan driver.
// master drives the time digits and 1 Hz pulse; slave drives the display.
interface clock_disp_scan_if;

    logic [3:0] SEC1;
    logic [2:0] SEC10;
    logic [3:0] MIN1;
    logic [2:0] MIN10;
    logic       EN1HZ;
    logic [3:0] DIG;
    logic [6:0] SEG;
    logic       DP;

    modport master (
        output SEC1, SEC10, MIN1, MIN10, EN1HZ,
        input  DIG, SEG, DP
    );

    modport slave (
        input  SEC1, SEC10, MIN1, MIN10, EN1HZ,
        output DIG, SEG, DP
    );

endinterface

// File: rtl/clock_disp_scan_dec.sv
// Combinational BCD to seven-segment decoder, active low.
// Codes above 9 show a dash so bad input is visible on the display.
module seg7_dec
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup with dash fallback for non-BCD codes
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_disp_scan.sv
// 4-digit multiplexed MM:SS display driver with frame snapshot and blanking.
// Define DISP_COLON_BLINK_EN to blink the colon from the EN1HZ pulse.
module clock_disp_scan
    import disp_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 250
) (
    input  logic              CLK,
    input  logic              RST,
    clock_disp_scan_if.slave  bus
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    logic [CW-1:0] div_cnt;
    logic [1:0]    slot;
    disp_time_t    snap;
    disp_time_t    live;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    code;
    logic [6:0]    dec_seg;

    logic [3:0]    dig_n;
    logic [6:0]    seg_n;
    logic          dp_n;

    logic [3:0]    dig_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    assign live = '{
        min10: bus.MIN10,
        min1:  bus.MIN1,
        sec10: bus.SEC10,
        sec1:  bus.SEC1
    };

    // End of slot and end of frame strobes
    always_comb begin
        slot_end  = (div_cnt == LAST);
        frame_end = slot_end && (slot == SLOT_M10);
    end

    // Scan prescaler and digit-slot rotator
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt <= '0;
            slot    <= SLOT_S1;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end)
                slot <= slot + 2'd1;
        end
    end

    // Latch the whole time once per frame so a frame never tears
    always_ff @(posedge CLK) begin
        if (RST)
            snap <= '0;
        else if (frame_end)
            snap <= live;
    end

    // Pick the snapshot digit for the active slot
    always_comb begin
        code = 4'd0;
        case (slot)
            SLOT_S1:  code = snap.sec1;
            SLOT_S10: code = {1'b0, snap.sec10};
            SLOT_M1:  code = snap.min1;
            SLOT_M10: code = {1'b0, snap.min10};
            default:  code = 4'd0;
        endcase
    end

    seg7_dec u_dec (
        .bcd (code),
        .seg (dec_seg)
    );

`ifdef DISP_COLON_BLINK_EN
    logic phase;

    // Colon blink phase, flips once per second
    always_ff @(posedge CLK) begin
        if (RST)
            phase <= 1'b0;
        else if (bus.EN1HZ)
            phase <= ~phase;
    end

    // Colon lit in the minutes-units slot during the on phase
    always_comb begin
        dp_n = ~((slot == SLOT_M1) && phase);
    end
`else
    // Colon steady on in the minutes-units slot
    always_comb begin
        dp_n = (slot != SLOT_M1);
    end
`endif

    // Next display values: anti-ghost blank and leading-zero blank
    always_comb begin
        seg_n = dec_seg;
        dig_n = 4'hF;
        if ((slot == SLOT_M10) && (snap.min10 == 3'd0))
            seg_n = SEG_OFF;
        if (div_cnt >= BLK)
            dig_n = ~(4'b0001 << slot);
    end

    // Output register stage
    always_ff @(posedge CLK) begin
        if (RST) begin
            dig_q <= 4'hF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            dig_q <= dig_n;
            seg_q <= seg_n;
            dp_q  <= dp_n;
        end
    end

    assign bus.DIG = dig_q;
    assign bus.SEG = seg_q;
    assign bus.DP  = dp_q;

endmodule

// File: tb/tb_clock_disp_scan.sv
// Self-checking bench for clock_disp_scan (SCAN_DIV=4, BLANK_CYC=1).
// Expected display derived from cycle count since reset and frame rules.
module tb_clock_disp_scan;

    localparam int SDIV = 4;
    localparam int BLNK = 1;
    localparam int FRM  = 4 * SDIV;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    clock_disp_scan_if bus();

    clock_disp_scan #(
        .SCAN_DIV  (SDIV),
        .BLANK_CYC (BLNK)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Reference state: cycles since reset, frame snapshot, colon phase
    int   n;
    int   ms1, ms10, mm1, mm10;
    bit   phase;
    logic [3:0] exp_dig;
    logic [6:0] exp_seg;
    logic       exp_dp;

    logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] ref_seg(input int slot, input int a,
                                           input int b, input int c,
                                           input int d);
        int v;
        case (slot)
            0: v = a;
            1: v = b;
            2: v = c;
            default: v = d;
        endcase
        if (slot == 3 && d == 0) return 7'h7F;
        if (v > 9) return 7'h3F;
        return tab[v];
    endfunction

    function automatic logic ref_dp(input int slot, input bit ph);
        if (slot != 2) return 1'b1;
`ifdef DISP_COLON_BLINK_EN
        return !ph;
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs follow the state held before each edge
    always @(posedge CLK) begin
        if (RST) begin
            n <= 0;
            ms1 <= 0; ms10 <= 0; mm1 <= 0; mm10 <= 0;
            phase <= 1'b0;
            exp_dig <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
        end else begin
            exp_dig <= ((n % SDIV) < BLNK) ? 4'hF
                     : ~(4'b0001 << ((n / SDIV) % 4));
            exp_seg <= ref_seg((n / SDIV) % 4, ms1, ms10, mm1, mm10);
            exp_dp  <= ref_dp((n / SDIV) % 4, phase);
            if ((n % FRM) == FRM - 1) begin
                ms1  <= int'(bus.SEC1);
                ms10 <= int'(bus.SEC10);
                mm1  <= int'(bus.MIN1);
                mm10 <= int'(bus.MIN10);
            end
            if (bus.EN1HZ) phase <= ~phase;
            n <= n + 1;
        end
    end

    task automatic set_time(input int m10, input int m1,
                            input int s10, input int s1);
        bus.MIN10 = 3'(m10);
        bus.MIN1  = 4'(m1);
        bus.SEC10 = 3'(s10);
        bus.SEC1  = 4'(s1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if ({bus.DIG, bus.SEG, bus.DP} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL reset: got %b/%h/%b want 1111/7f/1",
                     bus.DIG, bus.SEG, bus.DP);
        else passed++;
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({bus.DIG, bus.SEG, bus.DP} !== {4'hF, 7'h40, 1'b1})
            $display("FAIL reset_first: got %b/%h/%b want 1111/40/1",
                     bus.DIG, bus.SEG, bus.DP);
        else passed++;
        for (int i = 0; i < FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL zero_frame: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_1234();
        set_time(1, 2, 3, 4);
        for (int i = 0; i < 3 * FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL t1234: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_midframe();
        for (int i = 0; i < FRM && (n % FRM) != SDIV + 1; i++)
            @(negedge CLK);
        set_time(1, 2, 3, 5);
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL midframe: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_lead_zero();
        set_time(0, 5, 5, 9);
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL lead_zero: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        set_time(2, 12, 0, 7);
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL illegal: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_time($urandom_range(0, 7), $urandom_range(0, 15),
                         $urandom_range(0, 7), $urandom_range(0, 15));
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL random: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    task automatic test_blink();
        set_time(3, 4, 5, 6);
        for (int p = 0; p < 3; p++) begin
            repeat (2 * FRM) begin
                @(negedge CLK);
                total++;
                if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                    $display("FAIL blink: got %b/%h/%b want %b/%h/%b",
                             bus.DIG, bus.SEG, bus.DP,
                             exp_dig, exp_seg, exp_dp);
                else passed++;
            end
            for (int i = 0; i < FRM && (n % FRM) != FRM - 1; i++)
                @(negedge CLK);
            bus.EN1HZ = 1'b1;
            @(negedge CLK);
            bus.EN1HZ = 1'b0;
        end
        for (int i = 0; i < 300; i++) begin
            bus.EN1HZ = ($urandom_range(0, 9) == 0);
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL blink_rand: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
        bus.EN1HZ = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_time(4, 8, 2, 1);
        repeat (FRM + 6) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({bus.DIG, bus.SEG, bus.DP} !== {4'hF, 7'h7F, 1'b1})
            $display("FAIL reset_mid: got %b/%h/%b want 1111/7f/1",
                     bus.DIG, bus.SEG, bus.DP);
        else passed++;
        RST = 1'b0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge CLK);
            total++;
            if ({bus.DIG, bus.SEG, bus.DP} !== {exp_dig, exp_seg, exp_dp})
                $display("FAIL after_reset: got %b/%h/%b want %b/%h/%b",
                         bus.DIG, bus.SEG, bus.DP, exp_dig, exp_seg, exp_dp);
            else passed++;
        end
    endtask

    initial begin
        bus.EN1HZ = 1'b0;
        set_time(0, 0, 0, 0);
        test_reset();
        test_1234();
        test_midframe();
        test_lead_zero();
        test_illegal();
        test_random();
        test_blink();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
